// File: rtl/seg7_defs.sv
// Shared 7-segment definitions: one pattern table for the SEG7_LUT encoder and the scan decoder.
// Patterns are active-high {g,f,e,d,c,b,a}.
package seg7_defs;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // True when exactly one active-low digit enable is asserted.
  function automatic logic an_onehot(input logic [NUM_DIGITS-1:0] an);
    logic [NUM_DIGITS-1:0] low;
    low = ~an;
    return (low != 8'h00) && ((low & (low - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] an_index(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex decoder; hit is low for any pattern outside 0-F
// (including a blank digit).
module seg7_decode
  import seg7_defs::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       hit
);

  // Pattern lookup against the shared table.
  always_comb begin
    code = 4'h0;
    hit  = 1'b1;
    case (seg)
      SEG_0:   code = 4'h0;
      SEG_1:   code = 4'h1;
      SEG_2:   code = 4'h2;
      SEG_3:   code = 4'h3;
      SEG_4:   code = 4'h4;
      SEG_5:   code = 4'h5;
      SEG_6:   code = 4'h6;
      SEG_7:   code = 4'h7;
      SEG_8:   code = 4'h8;
      SEG_9:   code = 4'h9;
      SEG_A:   code = 4'hA;
      SEG_B:   code = 4'hB;
      SEG_C:   code = 4'hC;
      SEG_D:   code = 4'hD;
      SEG_E:   code = 4'hE;
      SEG_F:   code = 4'hF;
      default: begin
        code = 4'h0;
        hit  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Monitors a multiplexed 8-digit 7-segment bus, rebuilds per-digit hex/DP values,
// and flags completed scan frames, multi-hot enables and loss of scan activity.
module seg_scan_capture
  import seg7_defs::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        CP_1MHz,
  input  logic        nCLR,
  input  logic [7:0]  AN,
  input  logic [6:0]  C,
  input  logic        DP,
  output logic [31:0] oDIGITS,
  output logic [7:0]  oDOT,
  output logic [7:0]  oVALID,
  output logic        oFRAME,
  output logic        oERR,
  output logic        oSTALE
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);

  logic [7:0]    r_an, r_an_d;
  logic [6:0]    r_c, r_c_d;
  logic          r_dp, r_dp_d;
  logic [SW-1:0] r_settle;
  logic          r_fired;
  logic [31:0]   r_digits;
  logic [7:0]    r_dot;
  logic [7:0]    r_valid;
  logic [7:0]    r_mask;
  logic          r_frame;
  logic          r_err;
  logic [TW-1:0] r_to;
  logic          r_stale;

  logic          w_change;
  logic          w_eval;
  logic          w_onehot;
  logic          w_cap;
  logic          w_multi;
  logic [2:0]    w_idx;
  logic [3:0]    w_code;
  logic          w_hit;
  logic [TW-1:0] w_to_next;

  seg7_decode u_decode (
    .seg  (~r_c),
    .code (w_code),
    .hit  (w_hit)
  );

  // Dwell evaluation: one decision per stable dwell, taken when the settle count saturates.
  always_comb begin
    w_change  = {r_an, r_c, r_dp} != {r_an_d, r_c_d, r_dp_d};
    w_onehot  = an_onehot(r_an);
    w_idx     = an_index(r_an);
    w_eval    = (r_settle == SETTLE_MAX) && !r_fired;
    w_cap     = w_eval && w_onehot;
    w_multi   = w_eval && !w_onehot && (r_an != 8'hFF);
    if (w_cap) begin
      w_to_next = {TW{1'b0}};
    end else if (r_to != TO_MAX) begin
      w_to_next = r_to + TW'(1);
    end else begin
      w_to_next = r_to;
    end
  end

  // Input registers and their one-cycle-old copies used for change detection.
  always_ff @(posedge CP_1MHz or negedge nCLR) begin
    if (!nCLR) begin
      r_an   <= 8'hFF;
      r_c    <= 7'h7F;
      r_dp   <= 1'b1;
      r_an_d <= 8'hFF;
      r_c_d  <= 7'h7F;
      r_dp_d <= 1'b1;
    end else begin
      r_an   <= AN;
      r_c    <= C;
      r_dp   <= DP;
      r_an_d <= r_an;
      r_c_d  <= r_c;
      r_dp_d <= r_dp;
    end
  end

  // Settle counter; r_fired blocks a second decision until the inputs move again.
  always_ff @(posedge CP_1MHz or negedge nCLR) begin
    if (!nCLR) begin
      r_settle <= {SW{1'b0}};
      r_fired  <= 1'b0;
    end else if (w_change) begin
      r_settle <= {SW{1'b0}};
      r_fired  <= 1'b0;
    end else begin
      if (r_settle != SETTLE_MAX) begin
        r_settle <= r_settle + SW'(1);
      end
      if (w_eval) begin
        r_fired <= 1'b1;
      end
    end
  end

  // Per-digit storage; an unrecognised pattern stores zero and clears the valid bit.
  always_ff @(posedge CP_1MHz or negedge nCLR) begin
    if (!nCLR) begin
      r_digits <= 32'h0000_0000;
      r_dot    <= 8'h00;
      r_valid  <= 8'h00;
    end else if (w_cap) begin
      r_digits[{w_idx, 2'b00} +: 4] <= w_hit ? w_code : 4'h0;
      r_valid[w_idx]                <= w_hit;
      r_dot[w_idx]                  <= ~r_dp;
    end
  end

  // Frame mask: a full mask pulses oFRAME and clears on the following edge.
  always_ff @(posedge CP_1MHz or negedge nCLR) begin
    if (!nCLR) begin
      r_mask  <= 8'h00;
      r_frame <= 1'b0;
    end else if (r_mask == 8'hFF) begin
      r_mask  <= 8'h00;
      r_frame <= 1'b1;
    end else begin
      r_frame <= 1'b0;
      if (w_cap) begin
        r_mask[w_idx] <= 1'b1;
      end
    end
  end

  // Sticky multi-hot error and saturating inactivity timer.
  always_ff @(posedge CP_1MHz or negedge nCLR) begin
    if (!nCLR) begin
      r_err   <= 1'b0;
      r_to    <= {TW{1'b0}};
      r_stale <= 1'b0;
    end else begin
      if (w_multi) begin
        r_err <= 1'b1;
      end
      r_to    <= w_to_next;
      r_stale <= (w_to_next == TO_MAX);
    end
  end

  assign oDIGITS = r_digits;
  assign oDOT    = r_dot;
  assign oVALID  = r_valid;
  assign oFRAME  = r_frame;
  assign oERR    = r_err;
  assign oSTALE  = r_stale;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans, unstable/multi-hot/blank digits,
// inactivity timeout and mid-frame reset, with hand-computed expectations.
module tb_seg_scan_capture;

  logic        CP_1MHz;
  logic        nCLR;
  logic [7:0]  AN;
  logic [6:0]  C;
  logic        DP;
  logic [31:0] oDIGITS;
  logic [7:0]  oDOT;
  logic [7:0]  oVALID;
  logic        oFRAME;
  logic        oERR;
  logic        oSTALE;

  int checks;
  int failures;
  int frame_cnt;
  int last_frame;
  int last_chg;
  int frame_digit;
  int frame_at;
  int chg_at0;

  logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_capture dut (
    .CP_1MHz (CP_1MHz),
    .nCLR    (nCLR),
    .AN      (AN),
    .C       (C),
    .DP      (DP),
    .oDIGITS (oDIGITS),
    .oDOT    (oDOT),
    .oVALID  (oVALID),
    .oFRAME  (oFRAME),
    .oERR    (oERR),
    .oSTALE  (oSTALE)
  );

  initial CP_1MHz = 1'b0;
  always #5 CP_1MHz = ~CP_1MHz;

  task automatic dwell(input logic [7:0] an, input logic [6:0] c_n, input logic dp_n, input int n);
    logic [47:0] start;
    start = {oDIGITS, oDOT, oVALID};
    AN = an;
    C  = c_n;
    DP = dp_n;
    last_chg   = 0;
    last_frame = 0;
    for (int j = 1; j <= n; j++) begin
      @(negedge CP_1MHz);
      if (oFRAME) begin
        frame_cnt++;
        if (last_frame == 0) last_frame = j;
      end
      if (last_chg == 0 && {oDIGITS, oDOT, oVALID} != start) last_chg = j;
    end
  endtask

  task automatic scan(input logic [31:0] codes, input logic [7:0] dots, input logic [7:0] blanks,
                      input int upto);
    logic [6:0] pat;
    logic [7:0] an;
    for (int k = 0; k < upto; k++) begin
      pat = blanks[k] ? 7'h00 : seg_tab[codes[4*k +: 4]];
      an  = ~(8'h01 << k);
      dwell(an, ~pat, ~dots[k], 10);
      if (k == 0) chg_at0 = last_chg;
      if (last_frame != 0 && frame_digit < 0) begin
        frame_digit = k;
        frame_at    = last_frame;
      end
    end
    if (upto == 8) dwell(8'hFF, 7'h7F, 1'b1, 4);
  endtask

  task automatic do_reset();
    AN   = 8'hFF;
    C    = 7'h7F;
    DP   = 1'b1;
    nCLR = 1'b0;
    repeat (2) @(negedge CP_1MHz);
    nCLR = 1'b1;
    @(negedge CP_1MHz);
    frame_cnt   = 0;
    frame_digit = -1;
    frame_at    = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({oDIGITS, oDOT, oVALID, oFRAME, oERR, oSTALE} !== 51'd0) begin
      failures++;
      $display("FAIL %s: outputs got D=%h dot=%h v=%h f=%b e=%b s=%b expected all 0",
               tag, oDIGITS, oDOT, oVALID, oFRAME, oERR, oSTALE);
    end
  endtask

  task automatic test_reset();
    AN = 8'hFF; C = 7'h7F; DP = 1'b1; nCLR = 1'b0;
    repeat (2) @(negedge CP_1MHz);
    check_all_zero("reset_state");
    do_reset();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_scan();
    do_reset();
    scan(32'h7654_3210, 8'h55, 8'h00, 8);
    checks++; if (oDIGITS !== 32'h7654_3210) begin failures++; $display("FAIL scan_digits: got %h expected 76543210", oDIGITS); end
    checks++; if (oDOT !== 8'h55) begin failures++; $display("FAIL scan_dot: got %h expected 55", oDOT); end
    checks++; if (oVALID !== 8'hFF) begin failures++; $display("FAIL scan_valid: got %h expected ff", oVALID); end
    checks++; if (frame_cnt !== 1) begin failures++; $display("FAIL scan_frame_count: got %0d expected 1", frame_cnt); end
    checks++; if (frame_digit !== 7 || frame_at !== 8) begin failures++; $display("FAIL scan_frame_time: got digit %0d sample %0d expected digit 7 sample 8", frame_digit, frame_at); end
    checks++; if (chg_at0 !== 7) begin failures++; $display("FAIL capture_latency: got sample %0d expected 7", chg_at0); end
    checks++; if (oERR !== 1'b0 || oSTALE !== 1'b0) begin failures++; $display("FAIL scan_flags: got err=%b stale=%b expected 0 0", oERR, oSTALE); end
  endtask

  task automatic test_unstable();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      dwell(8'hFE, (i % 2 == 0) ? ~seg_tab[3] : ~seg_tab[8], 1'b1, 3);
    end
    checks++; if (oVALID !== 8'h00 || oDIGITS !== 32'h0) begin failures++; $display("FAIL unstable_nocap: got v=%h d=%h expected 00 0", oVALID, oDIGITS); end
    checks++; if (frame_cnt !== 0) begin failures++; $display("FAIL unstable_frame: got %0d expected 0", frame_cnt); end
  endtask

  task automatic test_multi_hot();
    dwell(8'hFC, ~seg_tab[1], 1'b1, 10);
    checks++; if (oERR !== 1'b1) begin failures++; $display("FAIL multi_err: got %b expected 1", oERR); end
    checks++; if (oVALID !== 8'h00) begin failures++; $display("FAIL multi_nocap: got %h expected 00", oVALID); end
    frame_cnt = 0; frame_digit = -1;
    scan(32'hFEDC_BA98, 8'h0F, 8'h00, 8);
    checks++; if (frame_cnt !== 1 || frame_digit !== 7) begin failures++; $display("FAIL multi_then_frame: got %0d frames at digit %0d expected 1 at 7", frame_cnt, frame_digit); end
    checks++; if (oDIGITS !== 32'hFEDC_BA98 || oDOT !== 8'h0F) begin failures++; $display("FAIL multi_then_data: got %h/%h expected fedcba98/0f", oDIGITS, oDOT); end
    checks++; if (oERR !== 1'b1) begin failures++; $display("FAIL multi_sticky: got %b expected 1", oERR); end
  endtask

  task automatic test_blank_digit();
    do_reset();
    scan(32'h9ABC_DEF0, 8'h00, 8'h08, 8);
    checks++; if (oVALID !== 8'hF7) begin failures++; $display("FAIL blank_valid: got %h expected f7", oVALID); end
    checks++; if (oDIGITS !== 32'h9ABC_0EF0) begin failures++; $display("FAIL blank_digits: got %h expected 9abc0ef0", oDIGITS); end
    checks++; if (frame_cnt !== 1) begin failures++; $display("FAIL blank_frame: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_stale();
    dwell(8'hFE, ~seg_tab[0], 1'b1, 10);
    dwell(8'hFF, 7'h7F, 1'b1, 4092);
    checks++; if (oSTALE !== 1'b0) begin failures++; $display("FAIL stale_early: got %b expected 0", oSTALE); end
    dwell(8'hFF, 7'h7F, 1'b1, 1);
    checks++; if (oSTALE !== 1'b1) begin failures++; $display("FAIL stale_at_timeout: got %b expected 1", oSTALE); end
    dwell(8'hFF, 7'h7F, 1'b1, 50);
    checks++; if (oSTALE !== 1'b1) begin failures++; $display("FAIL stale_hold: got %b expected 1", oSTALE); end
    dwell(8'hFB, ~seg_tab[5], 1'b1, 6);
    checks++; if (oSTALE !== 1'b1) begin failures++; $display("FAIL stale_before_cap: got %b expected 1", oSTALE); end
    dwell(8'hFB, ~seg_tab[5], 1'b1, 1);
    checks++; if (oSTALE !== 1'b0) begin failures++; $display("FAIL stale_clear: got %b expected 0", oSTALE); end
    checks++; if (oDIGITS[11:8] !== 4'h5 || oVALID[2] !== 1'b1) begin failures++; $display("FAIL stale_cap_data: got %h v=%b expected 5 1", oDIGITS[11:8], oVALID[2]); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    scan(32'h0000_4321, 8'h1F, 8'h00, 5);
    dwell(8'hDF, ~seg_tab[6], 1'b1, 3);
    nCLR = 1'b0;
    #1;
    check_all_zero("midreset_async");
    repeat (3) @(negedge CP_1MHz);
    check_all_zero("midreset_hold");
    nCLR = 1'b1;
    AN = 8'hFF; C = 7'h7F; DP = 1'b1;
    @(negedge CP_1MHz);
    frame_cnt = 0; frame_digit = -1; frame_at = 0;
    scan(32'h1357_9BDF, 8'hAA, 8'h00, 8);
    checks++; if (frame_cnt !== 1 || frame_digit !== 7 || frame_at !== 8) begin failures++; $display("FAIL midreset_frame: got %0d frames digit %0d sample %0d expected 1 7 8", frame_cnt, frame_digit, frame_at); end
    checks++; if (oDIGITS !== 32'h1357_9BDF || oDOT !== 8'hAA) begin failures++; $display("FAIL midreset_data: got %h/%h expected 13579bdf/aa", oDIGITS, oDOT); end
  endtask

  initial begin
    checks = 0; failures = 0; frame_cnt = 0; frame_digit = -1; frame_at = 0; chg_at0 = 0;
    nCLR = 1'b0; AN = 8'hFF; C = 7'h7F; DP = 1'b1;
    test_reset();
    test_scan();
    test_unstable();
    test_multi_hot();
    test_blank_digit();
    test_stale();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
